// File: rtl/mul_booth_seq.sv
// Iterative radix-4 Booth multiplier with valid/ready handshakes.
// Retires one Booth digit per clock into a registered accumulator and
// supports the RISC-V MUL, MULH, MULHSU and MULHU modes.
module mul_booth_seq #(
   parameter int unsigned XLEN = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [XLEN-1:0]       op1,
   input  logic [XLEN-1:0]       op2,
   input  logic [1:0]            mode,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [XLEN-1:0]       res,
   output logic [2*XLEN-1:0]     product,
   output logic                  busy
);

   localparam int unsigned AW   = 2*XLEN + 2;   // accumulator / extended multiplicand width
   localparam int unsigned BW   = XLEN + 3;     // extended multiplier plus implicit zero below bit 0
   localparam int unsigned NDIG = XLEN/2 + 1;   // Booth digits per operation
   localparam int unsigned CW   = $clog2(NDIG);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [AW-1:0]       mcand_q, mcand_d;
   logic [BW-1:0]       mplr_q, mplr_d;
   logic [1:0]          mode_q, mode_d;
   logic [AW-1:0]       acc_q, acc_d;
   logic [CW-1:0]       step_q, step_d;
   logic [2*XLEN-1:0]   product_q, product_d;
   logic [XLEN-1:0]     res_q, res_d;
   logic                in_ready_q, in_ready_d;
   logic                out_valid_q, out_valid_d;
   logic                busy_q, busy_d;

   logic                op1_sgn, op2_sgn;
   logic [AW-1:0]       ext_op1;
   logic [BW-1:0]       ext_op2;
   logic [2:0]          grp;
   logic                neg;
   logic [AW-1:0]       pp, addend, acc_sum;

   // Operand extension: op1 signed for MULH/MULHSU, op2 signed only for MULH.
   always_comb begin
      op1_sgn = (mode == 2'b01) || (mode == 2'b10);
      op2_sgn = (mode == 2'b01);
      ext_op1 = {{(AW-XLEN){op1_sgn & op1[XLEN-1]}}, op1};
      ext_op2 = {{2{op2_sgn & op2[XLEN-1]}}, op2, 1'b0};
   end

   // One Booth digit: select 0/1x/2x of the shifted multiplicand, negate by invert plus carry-in.
   always_comb begin
      grp = mplr_q[2:0];
      pp  = '0;
      neg = 1'b0;
      case (grp)
         3'b001, 3'b010: pp = mcand_q;
         3'b011:         pp = {mcand_q[AW-2:0], 1'b0};
         3'b100: begin
            pp  = {mcand_q[AW-2:0], 1'b0};
            neg = 1'b1;
         end
         3'b101, 3'b110: begin
            pp  = mcand_q;
            neg = 1'b1;
         end
         default: pp = '0;
      endcase
      addend  = neg ? ~pp : pp;
      acc_sum = acc_q + addend + AW'(neg);
   end

   // Next-state and registered-output logic.
   always_comb begin
      state_d   = state_q;
      mcand_d   = mcand_q;
      mplr_d    = mplr_q;
      mode_d    = mode_q;
      acc_d     = acc_q;
      step_d    = step_q;
      product_d = product_q;
      res_d     = res_q;

      case (state_q)
         S_IDLE: begin
            if (in_valid && in_ready_q) begin
               mcand_d = ext_op1;
               mplr_d  = ext_op2;
               mode_d  = mode;
               acc_d   = '0;
               step_d  = '0;
               state_d = S_CALC;
            end
         end
         S_CALC: begin
            acc_d   = acc_sum;
            mcand_d = {mcand_q[AW-3:0], 2'b00};
            mplr_d  = {2'b00, mplr_q[BW-1:2]};
            step_d  = step_q + CW'(1);
            if (step_q == CW'(NDIG-1)) begin
               step_d    = '0;
               product_d = acc_sum[2*XLEN-1:0];
               res_d     = (mode_q == 2'b00) ? acc_sum[XLEN-1:0] : acc_sum[2*XLEN-1:XLEN];
               state_d   = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      in_ready_d  = (state_d == S_IDLE);
      out_valid_d = (state_d == S_DONE);
      busy_d      = (state_d != S_IDLE);
   end

   // State and datapath registers; reset aborts any operation in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         mcand_q     <= '0;
         mplr_q      <= '0;
         mode_q      <= '0;
         acc_q       <= '0;
         step_q      <= '0;
         product_q   <= '0;
         res_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         mcand_q     <= mcand_d;
         mplr_q      <= mplr_d;
         mode_q      <= mode_d;
         acc_q       <= acc_d;
         step_q      <= step_d;
         product_q   <= product_d;
         res_q       <= res_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign res       = res_q;
   assign product   = product_q;

endmodule

// File: doc/mul_booth_seq.md
Name: mul_booth_seq

Overview:
- Iterative radix-4 Booth multiplier: the multi-cycle, parametrised counterpart to the team's combinational Booth/CSA multiplier.
- Retires one Booth digit per clock into a registered accumulator.
- Supports all four RISC-V M-extension multiply modes (MUL, MULH, MULHSU, MULHU).
- Sits behind a valid/ready handshake so it can hang off an execute stage that stalls while the multiply completes.

Parameters:
- XLEN, 32, operand width in bits. Must be even and at least 4.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  request presents op1/op2/mode.
- in_ready  output  1  block can accept a request; high only in IDLE.
- op1  input  XLEN  multiplicand.
- op2  input  XLEN  multiplier; Booth-encoded.
- mode  input  2  00 MUL, 01 MULH (s*s), 10 MULHSU (op1 signed, op2 unsigned), 11 MULHU (u*u).
- out_valid  output  1  result valid; held until it is consumed.
- out_ready  input  1  consumer takes the result.
- res  output  XLEN  selected result: product[XLEN-1:0] for mode 00, product[2XLEN-1:XLEN] otherwise.
- product  output  2*XLEN  full 2*XLEN-bit product.
- busy  output  1  high in CALC or DONE.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, res=0, product=0, step counter=0.
  - Reset asserted in any state (including mid-CALC) aborts the operation immediately.
  - No partial result is ever presented.
- FSM states are IDLE, CALC and DONE.
- IDLE:
  - in_ready=1.
  - On an edge where in_valid && in_ready, latch op1, op2 and mode, clear the accumulator and step counter, and go to CALC.
  - Operand or mode changes after the accept edge are ignored.
- Operand extension:
  - op1 is sign-extended (modes 01, 10) or zero-extended (modes 00, 11) to 2*XLEN+2 bits.
  - op2 is sign-extended (mode 01) or zero-extended (modes 00, 10, 11) to XLEN+2 bits.
  - Mode 00 low half is mode-independent; it is treated as unsigned.
- Digit count: N = XLEN/2 + 1 (17 for XLEN=32).
  - Group k is ext_op2[2k+1:2k-1], with an implicit 0 below bit 0.
- Booth digit table (group -> digit):
  - 000 and 111 -> 0.
  - 001 and 010 -> +1.
  - 011 -> +2.
  - 100 -> -2.
  - 101 and 110 -> -1.
- CALC, one step per clock:
  - acc += digit_k * (ext_op1 << 2k), modulo 2^(2*XLEN+2).
  - k increments; after step k=N-1, go to DONE.
  - Negation is two's complement (invert plus carry-in); no combinational multiplier is permitted.
- Entering DONE: register product = acc[2*XLEN-1:0] and res per mode. Both remain stable until the next operation enters DONE.
- Latency: out_valid rises exactly N clocks after the accept edge (17 for XLEN=32).
- DONE:
  - out_valid=1, in_ready=0.
  - On an edge with out_ready=1, go to IDLE; out_valid falls.
  - No back-to-back accept in the same cycle: the next request can be accepted at the earliest one cycle after the result handshake.
- Backpressure: out_valid, res and product are held indefinitely while out_ready=0. in_valid is ignored while busy.
- out_ready=1 while not in DONE has no effect.
- Overflow: none is possible. Every result is exact modulo 2^(2*XLEN).

Test Plan:
- MULH sign handling (XLEN=32, mode 01): op1=0xFFFFFFFF, op2=0x00000002.
  - Expect product=0xFFFFFFFF_FFFFFFFE and res=0xFFFFFFFF.
  - out_valid rises 17 clocks after accept.
- Unsigned and mixed modes, op1=op2=0xFFFFFFFF:
  - mode 11 -> product=0xFFFFFFFE_00000001, res=0xFFFFFFFE.
  - mode 10 -> product=0xFFFFFFFF_00000001, res=0xFFFFFFFF.
  - mode 00 -> res=0x00000001.
- Extremes, op1=op2=0x80000000:
  - mode 01 -> product=0x40000000_00000000, res=0x40000000.
  - mode 00 -> res=0x00000000.
  - mode 11 -> res=0x40000000.
- Backpressure: complete a mode 00 op 7*6, then hold out_ready=0 for 5 cycles while pulsing in_valid with other operands.
  - res=42 stays stable, in_ready stays 0, and the new request is not accepted.
  - Raise out_ready: the handshake occurs, then in_ready=1 on the next cycle.
- Reset mid-operation: assert rst asynchronously (off-edge) after step 8.
  - Outputs clear immediately: out_valid=0, product=0, in_ready=1.
  - A fresh 0x00001234*0x00000010 in mode 00 then gives res=0x00012340.
- Parameter sweep at XLEN=8 (N=5):
  - mode 01, 0x80*0x80 -> product=0x4000.
  - mode 11, 0xFF*0xFF -> product=0xFE01.
  - Random signed/unsigned vectors must match a reference model for all four modes.
